// File: rtl/memory_stage.sv
`default_nettype none
// ============================================================================
// Module      : memory_stage
// Description : Pipeline Memory stage. Registers the execute-stage results
//               toward Writeback, performs word loads/stores against a
//               single-port 2^DMEM_AW x 16 data RAM, and hosts one
//               memory-mapped LED register at LED_ADDR.
// Ports       :
//   I_CLOCK, I_RESET              clock, asynchronous active-high reset
//   I_LOCK                        execute-stage instruction valid
//   I_Opcode, I_ALUOut            opcode, ALU result / LDW-STW word address
//   I_StoreData                   STW data
//   I_DestRegIdx[V][_Idx], I_ALUOutV  scalar/vector destination + vector data
//   I_FetchStall, I_DepStall      upstream stall flags
//   O_*                           registered copies/results for Writeback
//   O_MemOut                      LDW result (zero for any non-LDW cycle)
//   O_LEDR                        LED register contents
// Revision    : 1.0 - initial release
// ============================================================================
module memory_stage #(
    parameter int                      DMEM_AW      = 10,
    parameter logic [15:0]             LED_ADDR     = 16'hFFF0,
    parameter int                      OPCODE_WIDTH = 8,
    parameter logic [OPCODE_WIDTH-1:0] OP_NOP       = OPCODE_WIDTH'('h00),
    parameter logic [OPCODE_WIDTH-1:0] OP_LDW       = OPCODE_WIDTH'('h21),
    parameter logic [OPCODE_WIDTH-1:0] OP_STW       = OPCODE_WIDTH'('h22)
) (
    input  logic                    I_CLOCK,
    input  logic                    I_RESET,
    input  logic                    I_LOCK,
    input  logic [OPCODE_WIDTH-1:0] I_Opcode,
    input  logic [15:0]             I_ALUOut,
    input  logic [15:0]             I_StoreData,
    input  logic [3:0]              I_DestRegIdx,
    input  logic [5:0]              I_DestRegIdxV,
    input  logic [1:0]              I_DestRegIdxV_Idx,
    input  logic [63:0]             I_ALUOutV,
    input  logic                    I_FetchStall,
    input  logic                    I_DepStall,
    output logic                    O_LOCK,
    output logic [OPCODE_WIDTH-1:0] O_Opcode,
    output logic [15:0]             O_ALUOut,
    output logic [15:0]             O_MemOut,
    output logic [3:0]              O_DestRegIdx,
    output logic [5:0]              O_DestRegIdxV,
    output logic [1:0]              O_DestRegIdxV_Idx,
    output logic [63:0]             O_ALUOutV,
    output logic                    O_FetchStall,
    output logic                    O_DepStall,
    output logic [15:0]             O_LEDR
);

    localparam int C_DMEM_DEPTH = 1 << DMEM_AW;

    // Data RAM: deliberately has no reset so contents survive I_RESET.
    logic [15:0] mem_q [C_DMEM_DEPTH];

    logic                    lock_q,   lock_d;
    logic [OPCODE_WIDTH-1:0] opcode_q, opcode_d;
    logic [15:0]             aluout_q, aluout_d;
    logic [15:0]             memout_q, memout_d;
    logic [3:0]              dst_q,    dst_d;
    logic [5:0]              dstv_q,   dstv_d;
    logic [1:0]              dstvi_q,  dstvi_d;
    logic [63:0]             aluoutv_q, aluoutv_d;
    logic                    fstall_q, fstall_d;
    logic                    dstall_q, dstall_d;
    logic [15:0]             ledr_q,   ledr_d;

    logic        w_active;
    logic        w_in_range;
    logic        w_is_led;
    logic        w_ram_we;
    logic [15:0] w_ram_rd;

    assign w_active   = I_LOCK & ~I_FetchStall & ~I_DepStall;
    // Any address bit at or above DMEM_AW set means the word is off the RAM.
    assign w_in_range = ((I_ALUOut >> DMEM_AW) == 16'h0000);
    assign w_is_led   = (I_ALUOut == LED_ADDR);
    assign w_ram_rd   = mem_q[I_ALUOut[DMEM_AW-1:0]];

    // The RAM has no reset path, so the write strobe itself must be blocked
    // while reset is high; otherwise a store racing reset would land.
    assign w_ram_we = w_active & ~I_RESET & (I_Opcode == OP_STW) &
                      ~w_is_led & w_in_range;

    always_comb begin
        lock_d    = I_LOCK;
        fstall_d  = I_FetchStall;
        dstall_d  = I_DepStall;
        opcode_d  = OP_NOP;
        aluout_d  = 16'h0000;
        memout_d  = 16'h0000;
        dst_d     = 4'h0;
        dstv_d    = 6'h00;
        dstvi_d   = 2'h0;
        aluoutv_d = 64'h0;
        ledr_d    = ledr_q;

        if (w_active) begin
            opcode_d  = I_Opcode;
            aluout_d  = I_ALUOut;
            dst_d     = I_DestRegIdx;
            dstv_d    = I_DestRegIdxV;
            dstvi_d   = I_DestRegIdxV_Idx;
            aluoutv_d = I_ALUOutV;

            if (I_Opcode == OP_LDW) begin
                if (w_is_led) begin
                    memout_d = ledr_q;
                end else if (w_in_range) begin
                    memout_d = w_ram_rd;
                end
            end

            if ((I_Opcode == OP_STW) && w_is_led) begin
                ledr_d = I_StoreData;
            end
        end
    end

    always_ff @(posedge I_CLOCK or posedge I_RESET) begin
        if (I_RESET) begin
            lock_q    <= 1'b0;
            opcode_q  <= OP_NOP;
            aluout_q  <= 16'h0000;
            memout_q  <= 16'h0000;
            dst_q     <= 4'h0;
            dstv_q    <= 6'h00;
            dstvi_q   <= 2'h0;
            aluoutv_q <= 64'h0;
            fstall_q  <= 1'b0;
            dstall_q  <= 1'b0;
            ledr_q    <= 16'h0000;
        end else begin
            lock_q    <= lock_d;
            opcode_q  <= opcode_d;
            aluout_q  <= aluout_d;
            memout_q  <= memout_d;
            dst_q     <= dst_d;
            dstv_q    <= dstv_d;
            dstvi_q   <= dstvi_d;
            aluoutv_q <= aluoutv_d;
            fstall_q  <= fstall_d;
            dstall_q  <= dstall_d;
            ledr_q    <= ledr_d;
        end
    end

    always_ff @(posedge I_CLOCK) begin
        if (w_ram_we) begin
            mem_q[I_ALUOut[DMEM_AW-1:0]] <= I_StoreData;
        end
    end

    assign O_LOCK            = lock_q;
    assign O_Opcode          = opcode_q;
    assign O_ALUOut          = aluout_q;
    assign O_MemOut          = memout_q;
    assign O_DestRegIdx      = dst_q;
    assign O_DestRegIdxV     = dstv_q;
    assign O_DestRegIdxV_Idx = dstvi_q;
    assign O_ALUOutV         = aluoutv_q;
    assign O_FetchStall      = fstall_q;
    assign O_DepStall        = dstall_q;
    assign O_LEDR            = ledr_q;

endmodule
`default_nettype wire

// File: tb/tb_memory_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_memory_stage
// Description : Scoreboard bench for memory_stage. Stimulus computes the
//               expected Writeback-side outputs from a behavioural model
//               (associative RAM + LED value) and queues them; a monitor
//               pops one entry per clock and compares.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_memory_stage;

    localparam logic [7:0]  OP_NOP  = 8'h00;
    localparam logic [7:0]  OP_LDW  = 8'h21;
    localparam logic [7:0]  OP_STW  = 8'h22;
    localparam logic [7:0]  OP_ADDI = 8'h11;
    localparam logic [7:0]  OP_VADD = 8'h30;
    localparam logic [15:0] LED     = 16'hFFF0;

    typedef struct {
        logic        lock;
        logic [7:0]  op;
        logic [15:0] alu;
        logic [15:0] mem;
        logic [3:0]  d;
        logic [5:0]  dv;
        logic [1:0]  dvi;
        logic [63:0] aluv;
        logic        fs;
        logic        ds;
        logic [15:0] led;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_lock = 1'b0, i_fs = 1'b0, i_ds = 1'b0;
    logic [7:0]  i_op = OP_NOP;
    logic [15:0] i_alu = '0, i_sd = '0;
    logic [3:0]  i_d = '0;
    logic [5:0]  i_dv = '0;
    logic [1:0]  i_dvi = '0;
    logic [63:0] i_aluv = '0;

    logic        o_lock, o_fs, o_ds;
    logic [7:0]  o_op;
    logic [15:0] o_alu, o_mem, o_led;
    logic [3:0]  o_d;
    logic [5:0]  o_dv;
    logic [1:0]  o_dvi;
    logic [63:0] o_aluv;

    int   n_pass = 0;
    int   n_total = 0;
    bit   hold = 1'b1;
    exp_t q[$];

    // Behavioural model state
    logic [15:0] ram_m[int];
    int          pool[$];
    logic [15:0] led_m = 16'h0000;

    always #5 clk = ~clk;

    memory_stage dut (
        .I_CLOCK          (clk),
        .I_RESET          (rst),
        .I_LOCK           (i_lock),
        .I_Opcode         (i_op),
        .I_ALUOut         (i_alu),
        .I_StoreData      (i_sd),
        .I_DestRegIdx     (i_d),
        .I_DestRegIdxV    (i_dv),
        .I_DestRegIdxV_Idx(i_dvi),
        .I_ALUOutV        (i_aluv),
        .I_FetchStall     (i_fs),
        .I_DepStall       (i_ds),
        .O_LOCK           (o_lock),
        .O_Opcode         (o_op),
        .O_ALUOut         (o_alu),
        .O_MemOut         (o_mem),
        .O_DestRegIdx     (o_d),
        .O_DestRegIdxV    (o_dv),
        .O_DestRegIdxV_Idx(o_dvi),
        .O_ALUOutV        (o_aluv),
        .O_FetchStall     (o_fs),
        .O_DepStall       (o_ds),
        .O_LEDR           (o_led)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        else n_pass++;
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, ".lock"}, 64'(o_lock), 64'd0);
        chk({tag, ".op"},   64'(o_op),   64'(OP_NOP));
        chk({tag, ".alu"},  64'(o_alu),  64'd0);
        chk({tag, ".mem"},  64'(o_mem),  64'd0);
        chk({tag, ".dst"},  64'({o_d, o_dv, o_dvi}), 64'd0);
        chk({tag, ".aluv"}, o_aluv, 64'd0);
        chk({tag, ".stall"}, 64'({o_fs, o_ds}), 64'd0);
        chk({tag, ".led"},  64'(o_led),  64'd0);
    endtask

    // Drive one instruction and queue what Writeback should see after the edge.
    task automatic drive_push(input logic lk, input logic fs, input logic ds,
                              input logic [7:0] op, input logic [15:0] alu,
                              input logic [15:0] sd, input logic [3:0] d,
                              input logic [5:0] dv, input logic [1:0] dvi,
                              input logic [63:0] aluv);
        exp_t e;
        bit   act;
        int   a;
        i_lock = lk; i_fs = fs; i_ds = ds; i_op = op; i_alu = alu; i_sd = sd;
        i_d = d; i_dv = dv; i_dvi = dvi; i_aluv = aluv;
        act    = lk && !fs && !ds;
        a      = int'(alu);
        e.lock = lk; e.fs = fs; e.ds = ds;
        e.op   = act ? op   : OP_NOP;
        e.alu  = act ? alu  : 16'h0;
        e.d    = act ? d    : 4'h0;
        e.dv   = act ? dv   : 6'h0;
        e.dvi  = act ? dvi  : 2'h0;
        e.aluv = act ? aluv : 64'h0;
        e.mem  = 16'h0;
        if (act && op == OP_LDW) begin
            if (alu == LED)    e.mem = led_m;
            else if (a < 1024) e.mem = ram_m.exists(a) ? ram_m[a] : 16'hxxxx;
        end
        if (act && op == OP_STW) begin
            if (alu == LED) led_m = sd;
            else if (a < 1024) begin
                if (!ram_m.exists(a)) pool.push_back(a);
                ram_m[a] = sd;
            end
        end
        e.led = led_m;
        q.push_back(e);
    endtask

    task automatic issue(input logic [7:0] op, input logic [15:0] alu,
                         input logic [15:0] sd, input logic [3:0] d,
                         input logic ds);
        @(negedge clk);
        drive_push(1'b1, 1'b0, ds, op, alu, sd, d, 6'h0, 2'h0, 64'h0);
    endtask

    // Monitor: DUT presents a new result every clock.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (!hold && q.size() > 0) begin
                e = q.pop_front();
                chk("lock",  64'(o_lock), 64'(e.lock));
                chk("op",    64'(o_op),   64'(e.op));
                chk("alu",   64'(o_alu),  64'(e.alu));
                chk("mem",   64'(o_mem),  64'(e.mem));
                chk("dst",   64'(o_d),    64'(e.d));
                chk("dstv",  64'(o_dv),   64'(e.dv));
                chk("dstvi", 64'(o_dvi),  64'(e.dvi));
                chk("aluv",  o_aluv,      e.aluv);
                chk("fstall",64'(o_fs),   64'(e.fs));
                chk("dstall",64'(o_ds),   64'(e.ds));
                chk("ledr",  64'(o_led),  64'(e.led));
            end
        end
    end

    initial begin
        int          sel;
        logic [7:0]  op;
        logic [15:0] addr;

        repeat (3) @(posedge clk);
        #1 chk_reset_values("reset");
        @(negedge clk);
        rst  = 1'b0;
        hold = 1'b0;
        drive_push(1'b0, 1'b0, 1'b0, OP_NOP, 16'h0, 16'h0, 4'h0, 6'h0, 2'h0, 64'h0);

        // Directed scenarios
        issue(OP_STW, 16'h03F0, 16'h5A5A, 4'h0, 1'b0);
        issue(OP_STW, 16'h03FF, 16'hC3C3, 4'h0, 1'b0);
        issue(OP_STW, 16'h0007, 16'h7777, 4'h0, 1'b0);
        issue(OP_STW, 16'h0005, 16'hBEEF, 4'h0, 1'b0);
        issue(OP_LDW, 16'h0005, 16'h0000, 4'h1, 1'b0);
        issue(OP_STW, LED,      16'h00A5, 4'h0, 1'b0);
        issue(OP_LDW, LED,      16'h0000, 4'h2, 1'b0);
        issue(OP_LDW, 16'h03F0, 16'h0000, 4'h2, 1'b0);
        issue(OP_STW, 16'h0005, 16'h1234, 4'h0, 1'b1);
        issue(OP_LDW, 16'h0005, 16'h0000, 4'h4, 1'b0);
        issue(OP_ADDI,16'h0042, 16'h0000, 4'h3, 1'b0);
        issue(OP_STW, 16'h0800, 16'hDEAD, 4'h0, 1'b0);
        issue(OP_LDW, 16'h0800, 16'h0000, 4'h5, 1'b0);
        issue(OP_LDW, 16'h0000 + 16'h03FF, 16'h0, 4'h6, 1'b0);
        issue(OP_LDW, LED,      16'h0000, 4'h7, 1'b0);

        // Asynchronous reset asserted mid-cycle while a store to 7 is presented
        @(negedge clk);
        hold   = 1'b1;
        i_lock = 1'b1; i_fs = 1'b0; i_ds = 1'b0;
        i_op   = OP_STW; i_alu = 16'h0007; i_sd = 16'hDEAD;
        #2 rst = 1'b1;
        #1 chk_reset_values("async_rst");
        @(posedge clk);
        #1 chk_reset_values("rst_hold");
        @(negedge clk);
        rst   = 1'b0;
        led_m = 16'h0000;
        hold  = 1'b0;
        drive_push(1'b0, 1'b0, 1'b0, OP_NOP, 16'h0, 16'h0, 4'h0, 6'h0, 2'h0, 64'h0);
        issue(OP_LDW, 16'h0007, 16'h0000, 4'h8, 1'b0);
        issue(OP_LDW, LED,      16'h0000, 4'h9, 1'b0);
        issue(OP_LDW, 16'h0005, 16'h0000, 4'hA, 1'b0);

        // Randomized traffic
        for (int n = 0; n < 300; n++) begin
            sel = int'($urandom_range(0, 4));
            case (sel)
                0:       op = OP_NOP;
                1:       op = OP_LDW;
                2:       op = OP_STW;
                3:       op = OP_ADDI;
                default: op = OP_VADD;
            endcase
            addr = 16'($urandom);
            if (op == OP_LDW || op == OP_STW) begin
                sel = int'($urandom_range(0, 9));
                if (sel == 0) addr = LED;
                else if (sel == 1) addr = 16'($urandom_range(16'h0400, 16'hFFFF));
                else if (op == OP_STW) addr = 16'($urandom_range(0, 1023));
                else addr = 16'(pool[$urandom_range(0, pool.size() - 1)]);
            end
            @(negedge clk);
            drive_push($urandom_range(0, 9) != 0, $urandom_range(0, 7) == 0,
                       $urandom_range(0, 7) == 0, op, addr, 16'($urandom),
                       4'($urandom), 6'($urandom), 2'($urandom),
                       {$urandom, $urandom});
        end

        @(negedge clk);
        drive_push(1'b0, 1'b0, 1'b0, OP_NOP, 16'h0, 16'h0, 4'h0, 6'h0, 2'h0, 64'h0);
        repeat (3) @(negedge clk);
        chk("drain", 64'(q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
